crlb_decide: RTL and testbench
==============================

CRLB_DECIDE -- requirements
Module: crlb_decide

Interface
REQ-001 SHALL provide parameter R, default 7, correlator base width.
REQ-002 SHALL provide parameter W, default 4*R+1, width of each signed correlator input and of the magnitude.
REQ-003 SHALL provide parameter WIN, default 80, number of valid samples per decision window (one symbol period).
REQ-004 SHALL provide parameter LOCK_N, default 3, consecutive aligned hits required to lock.
REQ-005 SHALL provide parameter LOSS_N, default 4, consecutive missed windows required to drop lock.
REQ-006 SHALL provide ports, one per line:
 Clk  in  1  single clock, all logic on rising edge.
 Reset  in  1  synchronous, active-high reset.
 V_in  in  1  V0..V3 valid this cycle.
 V0, V1, V2, V3  in  W each  signed correlator outputs, channels 0..3.
 Thr  in  W  unsigned detection threshold, sampled at window close.
 Sym  out  2  decided dibit, equal to the winning channel index.
 Sym_vld  out  1  one-cycle strobe qualifying Sym, Peak_idx and Peak_mag.
 Peak_idx  out  $clog2(WIN)  in-window sample index of the peak.
 Peak_mag  out  W  unsigned magnitude of the peak.
 Lock  out  1  high while the FSM is in LOCKED.

Function
REQ-007 Stage 1 SHALL register |Vk| for k=0..3 as W-bit unsigned; -2^(W-1) SHALL map to 2^(W-1) with no wrap.
REQ-008 Stage 2 SHALL select the max of the four magnitudes; ties SHALL go to the lowest channel index.
REQ-009 A sample counter SHALL advance only on valid samples, run 0..WIN-1, and wrap to 0 after WIN-1; gaps in V_in SHALL stall the pipeline without losing data.
REQ-010 Sample 0 of each window SHALL load the running peak unconditionally; later samples SHALL replace it only when strictly greater, so the earliest peak wins on ties.
REQ-011 At window close, the peak SHALL count as a hit when Peak_mag >= Thr, and as a miss otherwise.
REQ-012 Latency: results SHALL be registered 3 cycles after the V_in cycle of sample WIN-1.
REQ-013 A hit SHALL be aligned when |Peak_idx - previous hit Peak_idx| <= 1, with no wrap-around of the index.
REQ-014 The FSM SHALL have states SEARCH, VERIFY and LOCKED.
REQ-015 SEARCH: on a hit, the FSM SHALL store the index, set hit count to 1 and go to VERIFY.
REQ-016 VERIFY: on an aligned hit, the FSM SHALL increment the hit count and go to LOCKED when it reaches LOCK_N.
REQ-017 VERIFY: on a non-aligned hit, the FSM SHALL set hit count to 1 and store the new index.
REQ-018 VERIFY: on a miss, the FSM SHALL return to SEARCH.
REQ-019 LOCKED: a hit SHALL clear the miss count; a miss SHALL increment it, and at LOSS_N the FSM SHALL go to SEARCH.
REQ-020 Sym_vld SHALL pulse for a hit only when the FSM is in LOCKED or is entering LOCKED on that window.
REQ-021 Misses SHALL never assert Sym_vld.
REQ-022 Sym, Peak_idx and Peak_mag SHALL hold their last values between strobes.
REQ-023 Lock SHALL change in the same cycle as the window-close result.
REQ-024 Thr changes in the middle of a window SHALL affect only the compare at the next window close.

Reset
REQ-025 Reset SHALL clear Sym, Sym_vld, Peak_idx, Peak_mag and Lock to 0, the FSM to SEARCH, all counters, and the pipeline valid bits.
REQ-026 Reset in the middle of a window SHALL discard the partial window, and the first valid sample after reset SHALL be sample 0.
REQ-027 Reset SHALL take priority over V_in in the same cycle.

Verification
REQ-028 Reset case: assert Reset during active V_in -> every output is 0 the next cycle and Lock stays 0.
REQ-029 Single hit: Thr=1000, all inputs in ±10 except V2=-5000 at sample 37 -> no Sym_vld, FSM in VERIFY, Lock=0.
REQ-030 Lock acquisition: three consecutive windows with V2=-5000 at indices 37, 38, 37 -> Lock rises 3 cycles after the 3rd window's last sample, Sym_vld pulses once, Sym=2'b10, Peak_idx=37, Peak_mag=5000.
REQ-031 Tie case: while locked, V0=V3=3000 at the same sample 40 -> Sym=2'b00.
REQ-032 Loss of lock: while locked, four windows all below Thr -> no Sym_vld, and Lock falls at the 4th window close; a hit after three misses keeps Lock=1.
REQ-033 Boundary case: V1=-2^(W-1) at sample 0, then V_in low for 5 cycles in the middle of the window -> Peak_mag=2^(W-1), Peak_idx=0, and the window closes after exactly WIN valid samples.

Source files
------------

// File: rtl/crlb_decide.sv
// Four-channel correlator peak picker: per-window max-magnitude search, threshold
// decision and SEARCH/VERIFY/LOCKED symbol-timing lock, 3-cycle result latency.
module crlb_decide #(
    parameter int R      = 7,
    parameter int W      = 4*R+1,
    parameter int WIN    = 80,
    parameter int LOCK_N = 3,
    parameter int LOSS_N = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   V_in,
    input  logic [W-1:0]           V0,
    input  logic [W-1:0]           V1,
    input  logic [W-1:0]           V2,
    input  logic [W-1:0]           V3,
    input  logic [W-1:0]           Thr,
    output logic [1:0]             Sym,
    output logic                   Sym_vld,
    output logic [$clog2(WIN)-1:0] Peak_idx,
    output logic [W-1:0]           Peak_mag,
    output logic                   Lock
);

    // state  | meaning
    // SEARCH | no candidate timing, waiting for any hit
    // VERIFY | candidate index held, counting aligned hits toward LOCK_N
    // LOCKED | symbols emitted on hits, counting consecutive misses toward LOSS_N

    localparam int IW  = $clog2(WIN);
    localparam int HCW = $clog2(LOCK_N+1);
    localparam int MCW = $clog2(LOSS_N+1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(WIN-1);
    localparam logic [HCW-1:0] HIT_LOCK  = HCW'(LOCK_N);
    localparam logic [MCW-1:0] MISS_LOSS = MCW'(LOSS_N);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    // Unsigned result is W bits wide, so the most negative input maps to 2^(W-1).
    function automatic logic [W-1:0] abs_mag(input logic [W-1:0] x);
        return x[W-1] ? ((~x) + W'(1)) : x;
    endfunction

    logic [IW-1:0]  cnt_q;
    logic           s1_v, s1_last;
    logic [IW-1:0]  s1_idx;
    logic [W-1:0]   s1_mag [4];
    logic [W-1:0]   best_mag;
    logic [1:0]     best_ch;
    logic           s2_v, s2_last;
    logic [IW-1:0]  s2_idx;
    logic [W-1:0]   s2_mag;
    logic [1:0]     s2_ch;
    logic           close_q;
    logic [IW-1:0]  pk_idx;
    logic [W-1:0]   pk_mag;
    logic [1:0]     pk_ch;

    state_t         state_q, state_nxt;
    logic [HCW-1:0] hit_cnt_q, hit_cnt_nxt;
    logic [MCW-1:0] miss_cnt_q, miss_cnt_nxt;
    logic [IW-1:0]  ref_idx_q, ref_idx_nxt;
    logic           emit;
    logic           hit, miss, aligned;
    logic [IW-1:0]  idx_diff;

    // Sample index is attached at the input, so gaps in V_in only delay data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (V_in) begin
            cnt_q <= (cnt_q == IDX_LAST) ? '0 : cnt_q + IW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_idx  <= '0;
            for (int k = 0; k < 4; k++) s1_mag[k] <= '0;
        end else begin
            s1_v <= V_in;
            if (V_in) begin
                s1_idx    <= cnt_q;
                s1_last   <= (cnt_q == IDX_LAST);
                s1_mag[0] <= abs_mag(V0);
                s1_mag[1] <= abs_mag(V1);
                s1_mag[2] <= abs_mag(V2);
                s1_mag[3] <= abs_mag(V3);
            end
        end
    end

    always_comb begin
        best_mag = s1_mag[0];
        best_ch  = 2'd0;
        for (int k = 1; k < 4; k++) begin
            if (s1_mag[k] > best_mag) begin
                best_mag = s1_mag[k];
                best_ch  = 2'(k);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s2_v    <= 1'b0;
            s2_last <= 1'b0;
            s2_idx  <= '0;
            s2_mag  <= '0;
            s2_ch   <= '0;
        end else begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_idx  <= s1_idx;
                s2_last <= s1_last;
                s2_mag  <= best_mag;
                s2_ch   <= best_ch;
            end
        end
    end

    // Strict compare keeps the earliest sample on equal magnitudes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            close_q <= 1'b0;
            pk_idx  <= '0;
            pk_mag  <= '0;
            pk_ch   <= '0;
        end else begin
            close_q <= s2_v & s2_last;
            if (s2_v && ((s2_idx == '0) || (s2_mag > pk_mag))) begin
                pk_idx <= s2_idx;
                pk_mag <= s2_mag;
                pk_ch  <= s2_ch;
            end
        end
    end

    assign hit      = close_q & (pk_mag >= Thr);
    assign miss     = close_q & ~(pk_mag >= Thr);
    assign idx_diff = (pk_idx >= ref_idx_q) ? (pk_idx - ref_idx_q) : (ref_idx_q - pk_idx);
    assign aligned  = (idx_diff <= IW'(1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= SEARCH;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            ref_idx_q  <= '0;
        end else begin
            state_q    <= state_nxt;
            hit_cnt_q  <= hit_cnt_nxt;
            miss_cnt_q <= miss_cnt_nxt;
            ref_idx_q  <= ref_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        hit_cnt_nxt  = hit_cnt_q;
        miss_cnt_nxt = miss_cnt_q;
        ref_idx_nxt  = ref_idx_q;
        emit         = 1'b0;
        case (state_q)
            SEARCH: begin
                if (hit) begin
                    ref_idx_nxt = pk_idx;
                    hit_cnt_nxt = HCW'(1);
                    state_nxt   = VERIFY;
                end
            end
            VERIFY: begin
                if (hit) begin
                    ref_idx_nxt = pk_idx;
                    if (aligned) begin
                        hit_cnt_nxt = hit_cnt_q + HCW'(1);
                        if (hit_cnt_q + HCW'(1) == HIT_LOCK) begin
                            state_nxt    = LOCKED;
                            miss_cnt_nxt = '0;
                            emit         = 1'b1;
                        end
                    end else begin
                        hit_cnt_nxt = HCW'(1);
                    end
                end else if (miss) begin
                    hit_cnt_nxt = '0;
                    state_nxt   = SEARCH;
                end
            end
            LOCKED: begin
                if (hit) begin
                    ref_idx_nxt  = pk_idx;
                    miss_cnt_nxt = '0;
                    emit         = 1'b1;
                end else if (miss) begin
                    miss_cnt_nxt = miss_cnt_q + MCW'(1);
                    if (miss_cnt_q + MCW'(1) == MISS_LOSS) begin
                        miss_cnt_nxt = '0;
                        hit_cnt_nxt  = '0;
                        state_nxt    = SEARCH;
                    end
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Sym      <= '0;
            Sym_vld  <= 1'b0;
            Peak_idx <= '0;
            Peak_mag <= '0;
        end else begin
            Sym_vld <= emit;
            if (emit) begin
                Sym      <= pk_ch;
                Peak_idx <= pk_idx;
                Peak_mag <= pk_mag;
            end
        end
    end

    assign Lock = (state_q == LOCKED);

endmodule

// File: tb/tb_crlb_decide.sv
// Bench for crlb_decide: directed window table, hand corner sequences and random
// windows, all checked every cycle against a window-level reference model.
module tb_crlb_decide;
    localparam int R = 7, W = 4*R+1, WIN = 80, LOCK_N = 3, LOSS_N = 4;
    localparam int IW = $clog2(WIN);

    logic          Clk = 1'b0;
    logic          Reset, V_in;
    logic [W-1:0]  V0, V1, V2, V3, Thr;
    logic [1:0]    Sym;
    logic          Sym_vld;
    logic [IW-1:0] Peak_idx;
    logic [W-1:0]  Peak_mag;
    logic          Lock;

    crlb_decide #(.R(R), .W(W), .WIN(WIN), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) dut (
        .Clk(Clk), .Reset(Reset), .V_in(V_in),
        .V0(V0), .V1(V1), .V2(V2), .V3(V3), .Thr(Thr),
        .Sym(Sym), .Sym_vld(Sym_vld), .Peak_idx(Peak_idx), .Peak_mag(Peak_mag), .Lock(Lock)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0, n_fail = 0, edge_n = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model: collect a whole window, pick its peak by brute force,
    // apply the lock rules when the result is due.
    localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;
    typedef struct {int due; int ch; int idx; longint mag;} rec_t;
    rec_t        pend[$];
    logic [W-1:0] win_s [WIN][4];
    int          m_cnt, m_st, m_hits, m_miss, m_prev;
    logic        e_vld, e_lock;
    int          e_sym, e_idx;
    longint      e_mag;

    function automatic longint mag_of(input logic [W-1:0] v);
        longint s;
        s = longint'($signed(v));
        return (s < 0) ? -s : s;
    endfunction

    function automatic logic [W-1:0] to_w(input longint v);
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] noise();
        longint n;
        n = longint'($urandom_range(0, 20)) - 10;
        return n[W-1:0];
    endfunction

    task automatic model_reset();
        pend.delete();
        m_cnt = 0; m_st = M_SEARCH; m_hits = 0; m_miss = 0; m_prev = 0;
        e_vld = 0; e_lock = 0; e_sym = 0; e_idx = 0; e_mag = 0;
    endtask

    task automatic model_decide(input rec_t r);
        bit hit;
        bit emit;
        hit  = (r.mag >= longint'(Thr));
        emit = 0;
        if (m_st == M_SEARCH) begin
            if (hit) begin m_prev = r.idx; m_hits = 1; m_st = M_VERIFY; end
        end else if (m_st == M_VERIFY) begin
            if (!hit) m_st = M_SEARCH;
            else if ((r.idx - m_prev <= 1) && (m_prev - r.idx <= 1)) begin
                m_hits++;
                m_prev = r.idx;
                if (m_hits == LOCK_N) begin m_st = M_LOCKED; m_miss = 0; emit = 1; end
            end else begin
                m_hits = 1; m_prev = r.idx;
            end
        end else begin
            if (hit) begin m_miss = 0; emit = 1; m_prev = r.idx; end
            else begin
                m_miss++;
                if (m_miss == LOSS_N) m_st = M_SEARCH;
            end
        end
        if (emit) begin e_vld = 1; e_sym = r.ch; e_idx = r.idx; e_mag = r.mag; end
        e_lock = (m_st == M_LOCKED);
    endtask

    task automatic model_edge();
        longint best, m;
        int bi, bc;
        rec_t r;
        if (Reset) begin model_reset(); return; end
        e_vld = 0;
        while (pend.size() > 0 && pend[0].due == edge_n) begin
            r = pend.pop_front();
            model_decide(r);
        end
        if (V_in) begin
            win_s[m_cnt][0] = V0; win_s[m_cnt][1] = V1;
            win_s[m_cnt][2] = V2; win_s[m_cnt][3] = V3;
            m_cnt++;
            if (m_cnt == WIN) begin
                best = -1; bi = 0; bc = 0;
                for (int i = 0; i < WIN; i++)
                    for (int k = 0; k < 4; k++) begin
                        m = mag_of(win_s[i][k]);
                        if (m > best) begin best = m; bi = i; bc = k; end
                    end
                pend.push_back('{edge_n + 3, bc, bi, best});
                m_cnt = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        edge_n++;
        model_edge();
        @(negedge Clk);
        chk("sym_vld", Sym_vld, e_vld);
        chk("lock", Lock, e_lock);
        chk("sym", Sym, e_sym);
        chk("peak_idx", Peak_idx, e_idx);
        chk("peak_mag", Peak_mag, e_mag);
    endtask

    task automatic drive_window(input logic [3:0] mask, input longint val, input int pos,
                                input int gap_at, input int gap_len);
        for (int s = 0; s < WIN; s++) begin
            if (s == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    V_in = 0;
                    V0 = W'($urandom); V1 = W'($urandom); V2 = W'($urandom); V3 = W'($urandom);
                    tick();
                end
            end
            V_in = 1;
            V0 = (mask[0] && s == pos) ? to_w(val) : noise();
            V1 = (mask[1] && s == pos) ? to_w(val) : noise();
            V2 = (mask[2] && s == pos) ? to_w(val) : noise();
            V3 = (mask[3] && s == pos) ? to_w(val) : noise();
            tick();
        end
        V_in = 0;
    endtask

    // Called right after the last sample of a window: result lands on the third edge.
    task automatic close_check(input string name, input logic x_vld, input logic x_lock,
                               input int x_sym, input int x_idx, input longint x_mag);
        tick();
        tick();
        chk({name, "_early_vld"}, Sym_vld, 0);
        tick();
        chk({name, "_vld"}, Sym_vld, x_vld);
        chk({name, "_lock"}, Lock, x_lock);
        chk({name, "_sym"}, Sym, x_sym);
        chk({name, "_idx"}, Peak_idx, x_idx);
        chk({name, "_mag"}, Peak_mag, x_mag);
        tick();
    endtask

    typedef struct {
        logic [3:0] mask; longint val; int pos;
        logic x_vld; logic x_lock; int x_sym; int x_idx; longint x_mag;
    } vec_t;
    vec_t tbl[12];

    initial begin
        tbl[0]  = '{4'b0100, -5000, 37, 0, 0, 0,  0,  0};
        tbl[1]  = '{4'b0100, -5000, 38, 0, 0, 0,  0,  0};
        tbl[2]  = '{4'b0100, -5000, 37, 1, 1, 2, 37, 5000};
        tbl[3]  = '{4'b1001,  3000, 40, 1, 1, 0, 40, 3000};
        tbl[4]  = '{4'b0000,     0,  0, 0, 1, 0, 40, 3000};
        tbl[5]  = '{4'b0000,     0,  0, 0, 1, 0, 40, 3000};
        tbl[6]  = '{4'b0000,     0,  0, 0, 1, 0, 40, 3000};
        tbl[7]  = '{4'b0100, -5000, 37, 1, 1, 2, 37, 5000};
        tbl[8]  = '{4'b0000,     0,  0, 0, 1, 2, 37, 5000};
        tbl[9]  = '{4'b0000,     0,  0, 0, 1, 2, 37, 5000};
        tbl[10] = '{4'b0000,     0,  0, 0, 1, 2, 37, 5000};
        tbl[11] = '{4'b0000,     0,  0, 0, 0, 2, 37, 5000};

        Reset = 1; V_in = 0; V0 = '0; V1 = '0; V2 = '0; V3 = '0; Thr = to_w(1000);
        model_reset();
        tick();
        tick();
        chk("reset_sym_vld", Sym_vld, 0);
        chk("reset_lock", Lock, 0);
        chk("reset_sym", Sym, 0);
        chk("reset_idx", Peak_idx, 0);
        chk("reset_mag", Peak_mag, 0);
        Reset = 0;
        tick();

        for (int i = 0; i < 12; i++) begin
            drive_window(tbl[i].mask, tbl[i].val, tbl[i].pos, -1, 0);
            close_check($sformatf("tbl%0d", i), tbl[i].x_vld, tbl[i].x_lock,
                        tbl[i].x_sym, tbl[i].x_idx, tbl[i].x_mag);
        end

        // Most negative input at sample 0, threshold exactly equal, gap mid-window.
        Thr = to_w(longint'(1) << (W-1));
        drive_window(4'b0010, -(longint'(1) << (W-1)), 0, 40, 5);
        close_check("bnd0", 0, 0, 2, 37, 5000);
        drive_window(4'b0010, -(longint'(1) << (W-1)), 0, 40, 5);
        close_check("bnd1", 0, 0, 2, 37, 5000);
        drive_window(4'b0010, -(longint'(1) << (W-1)), 0, 40, 5);
        close_check("bnd2", 1, 1, 1, 0, longint'(1) << (W-1));

        // Reset mid-window with V_in active.
        Thr = to_w(1000);
        for (int s = 0; s < 30; s++) begin
            V_in = 1; V0 = noise(); V1 = noise(); V2 = noise(); V3 = noise();
            tick();
        end
        Reset = 1;
        tick();
        chk("midrst_vld", Sym_vld, 0);
        chk("midrst_lock", Lock, 0);
        chk("midrst_sym", Sym, 0);
        chk("midrst_idx", Peak_idx, 0);
        chk("midrst_mag", Peak_mag, 0);
        Reset = 0; V_in = 0;
        tick();
        chk("midrst_lock_stays", Lock, 0);
        drive_window(4'b1000, -4000, 10, -1, 0);
        close_check("post0", 0, 0, 0, 0, 0);
        drive_window(4'b1000, -4000, 10, -1, 0);
        close_check("post1", 0, 0, 0, 0, 0);
        drive_window(4'b1000, -4000, 10, -1, 0);
        close_check("post2", 1, 1, 3, 10, 4000);

        for (int w = 0; w < 30; w++) begin
            int pos, ch, s, tie;
            longint val;
            pos = ($urandom_range(0, 99) < 85) ? 30 + int'($urandom_range(0, 2))
                                               : int'($urandom_range(0, WIN-1));
            ch  = int'($urandom_range(0, 3));
            tie = ($urandom_range(0, 9) == 0) ? 1 : 0;
            val = longint'($urandom_range(500, 4000));
            if ($urandom_range(0, 1) == 1) val = -val;
            if ($urandom_range(0, 15) == 0) val = -(longint'(1) << (W-1));
            s = 0;
            while (s < WIN) begin
                if ($urandom_range(0, 99) < 10) begin
                    V_in = 0;
                    V0 = W'($urandom); V1 = W'($urandom); V2 = W'($urandom); V3 = W'($urandom);
                    tick();
                    continue;
                end
                if ($urandom_range(0, 999) < 2) begin
                    Reset = 1; V_in = 1;
                    tick();
                    Reset = 0;
                    s = 0;
                    continue;
                end
                if ($urandom_range(0, 99) < 2) Thr = W'($urandom_range(800, 3000));
                V_in = 1;
                V0 = noise(); V1 = noise(); V2 = noise(); V3 = noise();
                if ($urandom_range(0, 199) == 0) V1 = W'($urandom);
                if (s == pos) begin
                    case (ch)
                        0: V0 = to_w(val);
                        1: V1 = to_w(val);
                        2: V2 = to_w(val);
                        default: V3 = to_w(val);
                    endcase
                    if (tie == 1) V3 = to_w(-val);
                end
                tick();
                s++;
            end
            V_in = 0;
            repeat ($urandom_range(0, 4)) tick();
        end
        V_in = 0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
